dig_bcd_ctrl: RTL and testbench

//   Sequential binary-to-BCD controller for the digit-tube (DIG) MMIO path.

---
 rtl/dig_bcd_ctrl_pkg.sv | 21 ++
 rtl/dig_bcd_ctrl_bcd_add3.sv | 12 +
 rtl/dig_bcd_ctrl.sv | 150 +++++++++++++++
 tb/tb_dig_bcd_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dig_bcd_ctrl_pkg.sv
// Shared DIG digit-tube constants used by memorio, the scan driver and the
// binary-to-BCD controller.
package dig_bcd_ctrl_pkg;

    localparam int unsigned DIG_DIGITS    = 8;
    localparam int unsigned DIG_BIN_W     = 26;
    localparam logic [31:0] DIG_MMIO_ADDR = 32'hFFFF_FC00;

    // True when every BIN_W-bit operand fits in DIGITS decimal digits.
    function automatic bit dig_fits(input int unsigned bin_w, input int unsigned digits);
        longint unsigned p2;
        longint unsigned p10;
        if (bin_w >= 63 || digits >= 19) return 1'b0;
        p2  = 1;
        p10 = 1;
        for (int unsigned i = 0; i < bin_w; i++) p2 = p2 * 2;
        for (int unsigned i = 0; i < digits; i++) p10 = p10 * 10;
        return p2 <= p10;
    endfunction

endpackage

// File: rtl/dig_bcd_ctrl_bcd_add3.sv
// Single BCD digit correction cell for the shift-and-add-3 converter.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) digit_o = digit_i + 4'd3;
    end

endmodule

// File: rtl/dig_bcd_ctrl.sv
// Sequential binary-to-BCD controller for the DIG MMIO path: one bit per clock,
// one-deep pending buffer so CPU stores never stall.
module dig_bcd_ctrl
    import dig_bcd_ctrl_pkg::*;
#(
    parameter int unsigned BIN_W  = DIG_BIN_W,
    parameter int unsigned DIGITS = DIG_DIGITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  digcs,
    input  logic                  digwrite,
    input  logic [BIN_W-1:0]      wdata,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy,
    output logic                  done,
    output logic                  valid
);

    localparam int unsigned BW    = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    if (!dig_fits(BIN_W, DIGITS)) begin : g_param_err
        $error("dig_bcd_ctrl: 2**BIN_W exceeds 10**DIGITS");
    end

    logic [1:0]       state_q,  state_d;
    logic [BIN_W-1:0] opnd_q,   opnd_d;
    logic [BW-1:0]    work_q,   work_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [BIN_W-1:0] pend_q,   pend_d;
    logic             pend_v_q, pend_v_d;
    logic [BW-1:0]    bcd_q,    bcd_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             valid_q,  valid_d;

    logic             req;
    logic             start;
    logic [BIN_W-1:0] start_val;
    logic [BW-1:0]    adj;

    assign req = digcs & digwrite;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (work_q[4*g +: 4]),
            .digit_o (adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d   = state_q;
        opnd_d    = opnd_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        bcd_d     = bcd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        start     = 1'b0;
        start_val = wdata;

        case (state_q)
            ST_IDLE: begin
                start = req;
            end
            ST_SHIFT: begin
                // Correction precedes the shift; the dropped MSB is always zero.
                work_d = BW'({adj, opnd_q[BIN_W-1]});
                opnd_d = opnd_q << 1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (req) begin
                    pend_d   = wdata;
                    pend_v_d = 1'b1;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end
            end
            ST_DONE: begin
                bcd_d   = work_q;
                done_d  = 1'b1;
                valid_d = 1'b1;
                if (req) begin
                    start    = 1'b1;
                    pend_v_d = 1'b0;
                end else if (pend_v_q) begin
                    start     = 1'b1;
                    start_val = pend_q;
                    pend_v_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (start) begin
            opnd_d  = start_val;
            work_d  = '0;
            cnt_d   = CNT_W'(BIN_W);
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            opnd_q   <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            bcd_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opnd_q   <= opnd_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            bcd_q    <= bcd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
        end
    end

    assign bcd_out = bcd_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_dig_bcd_ctrl.sv
// Self-checking bench for dig_bcd_ctrl: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_dig_bcd_ctrl;

    localparam int unsigned BIN_W  = 26;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned BW     = 4 * DIGITS;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             digcs = 1'b0;
    logic             digwrite = 1'b0;
    logic [BIN_W-1:0] wdata = '0;
    logic [BW-1:0]    bcd_out;
    logic             busy, done, valid;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    dig_bcd_ctrl #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clock    (clock),
        .reset    (reset),
        .digcs    (digcs),
        .digwrite (digwrite),
        .wdata    (wdata),
        .bcd_out  (bcd_out),
        .busy     (busy),
        .done     (done),
        .valid    (valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] to_bcd(input longint unsigned v);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference model: a conversion started at some edge completes BIN_W+1
    // edges later; requests in the meantime park in a newest-wins slot.
    logic [BW-1:0]    exp_bcd;
    logic             exp_busy, exp_done, exp_valid;
    bit               m_active, m_pend_v;
    int               m_age;
    logic [BIN_W-1:0] m_opnd, m_pend;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            exp_bcd = '0; exp_busy = 0; exp_done = 0; exp_valid = 0;
            m_active = 0; m_pend_v = 0; m_age = 0; m_opnd = '0; m_pend = '0;
        end else begin
            exp_done = 0;
            if (m_active) begin
                m_age++;
                if (m_age == BIN_W + 1) begin
                    exp_bcd   = to_bcd(longint'(m_opnd));
                    exp_done  = 1;
                    exp_valid = 1;
                    if (digcs && digwrite) begin
                        m_opnd = wdata; m_age = 0; m_pend_v = 0;
                    end else if (m_pend_v) begin
                        m_opnd = m_pend; m_age = 0; m_pend_v = 0;
                    end else begin
                        m_active = 0;
                    end
                end else if (digcs && digwrite) begin
                    m_pend = wdata; m_pend_v = 1;
                end
            end else if (digcs && digwrite) begin
                m_active = 1; m_opnd = wdata; m_age = 0;
            end
            exp_busy = m_active && (m_age < BIN_W);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            bit over9;
            check("bcd_out", 64'(bcd_out), 64'(exp_bcd));
            check("busy",    64'(busy),    64'(exp_busy));
            check("done",    64'(done),    64'(exp_done));
            check("valid",   64'(valid),   64'(exp_valid));
            over9 = 0;
            for (int i = 0; i < DIGITS; i++) if (bcd_out[4*i +: 4] > 4'd9) over9 = 1;
            check("digit_range", 64'(over9), 64'd0);
        end
    end

    // All stimulus is applied 1 time unit after a rising edge.
    task automatic pulse_req(input logic [BIN_W-1:0] v);
        digcs = 1; digwrite = 1; wdata = v;
        @(posedge clock); #1;
        digcs = 0; digwrite = 0;
    endtask

    task automatic wait_done(output int n, output logic [BW-1:0] r, output int busy_hi);
        n = -1; r = '0; busy_hi = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clock); #1;
            if (busy) busy_hi++;
            if (done) begin
                n = k; r = bcd_out;
                return;
            end
        end
        check("done_timeout", 64'd1, 64'd0);
    endtask

    int            lat, bh;
    logic [BW-1:0] res;

    initial begin
        repeat (2) @(posedge clock);
        chk_en = 1;
        #1;
        check("reset_bcd",   64'(bcd_out), 64'd0);
        check("reset_valid", 64'(valid),   64'd0);
        @(posedge clock); #1;
        reset = 0;
        @(posedge clock); #1;

        pulse_req(0);
        wait_done(lat, res, bh);
        check("t1_latency", 64'(lat), 64'd27);
        check("t1_bcd",     64'(res), 64'h00000000);
        check("t1_valid",   64'(valid), 64'd1);
        repeat (3) @(posedge clock); #1;

        pulse_req(12345);
        bh = busy ? 1 : 0;
        begin
            int b2;
            wait_done(lat, res, b2);
            bh += b2;
        end
        check("t2_busy_cycles", 64'(bh),  64'd26);
        check("t2_latency",     64'(lat), 64'd27);
        check("t2_bcd",         64'(res), 64'h00012345);
        repeat (2) @(posedge clock); #1;

        pulse_req(26'd67108863);
        wait_done(lat, res, bh);
        check("t3_bcd", 64'(res), 64'h67108863);
        repeat (2) @(posedge clock); #1;

        pulse_req(99);
        repeat (4) @(posedge clock); #1;
        pulse_req(100);
        repeat (6) @(posedge clock); #1;
        pulse_req(7);
        wait_done(lat, res, bh);
        check("t4_first_bcd", 64'(res), 64'h00000099);
        wait_done(lat, res, bh);
        check("t4_gap",        64'(lat), 64'd27);
        check("t4_second_bcd", 64'(res), 64'h00000007);
        repeat (2) @(posedge clock); #1;

        digcs = 1; digwrite = 0; wdata = 26'd555;
        repeat (4) @(posedge clock); #1;
        digcs = 0; digwrite = 1;
        repeat (4) @(posedge clock); #1;
        digwrite = 0;
        check("t5_busy", 64'(busy),    64'd0);
        check("t5_done", 64'(done),    64'd0);
        check("t5_bcd",  64'(bcd_out), 64'h00000007);

        pulse_req(12345);
        repeat (9) @(posedge clock); #1;
        reset = 1;
        #1;
        check("t6_rst_bcd",   64'(bcd_out), 64'd0);
        check("t6_rst_busy",  64'(busy),    64'd0);
        check("t6_rst_valid", 64'(valid),   64'd0);
        repeat (2) @(posedge clock); #1;
        reset = 0;
        @(posedge clock); #1;
        pulse_req(5);
        wait_done(lat, res, bh);
        check("t6_bcd", 64'(res), 64'h00000005);

        // Reset while in DONE: the completion must not become visible.
        repeat (2) @(posedge clock); #1;
        pulse_req(42);
        repeat (26) @(posedge clock); #1;
        reset = 1;
        @(posedge clock); #1;
        check("rd_done", 64'(done),    64'd0);
        check("rd_bcd",  64'(bcd_out), 64'd0);
        reset = 0;
        @(posedge clock); #1;

        for (int c = 0; c < 1500; c++) begin
            int unsigned r;
            r = $urandom_range(0, 15);
            digcs = 0; digwrite = 0;
            if (c == 700 || c == 701) reset = 1;
            else reset = 0;
            if (r <= 1) begin
                digcs = 1; digwrite = 1; wdata = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
            end else if (r == 2) begin
                digcs = 1; digwrite = 1;
                case ($urandom_range(0, 3))
                    0: wdata = '0;
                    1: wdata = '1;
                    2: wdata = 26'd9999999;
                    default: wdata = 26'd10000000;
                endcase
            end else if (r == 3) begin
                digcs = 1; wdata = BIN_W'($urandom);
            end else if (r == 4) begin
                digwrite = 1; wdata = BIN_W'($urandom);
            end
            @(posedge clock); #1;
        end
        digcs = 0; digwrite = 0; reset = 0;
        repeat (120) @(posedge clock);
        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
